// File: rtl/vif_rr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one valid/ready data channel among
// NUM_REQ requesters, with a one-entry registered output tagged by source index.
module vif_rr_arbiter #(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_en;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] others;
    logic [SRC_W:0]     idle_pick;
    logic [SRC_W:0]     rot_pick;
    logic               keep_owner;
    logic               grant_hit;
    logic [SRC_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;

    // First set bit of v scanning upward from base with wrap; MSB flags a hit.
    function automatic logic [SRC_W:0] scan(input logic [NUM_REQ-1:0] v,
                                            input int unsigned base);
        logic [SRC_W:0] r;
        int unsigned    idx;
        r = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (base + k) % NUM_REQ;
            if (!r[SRC_W] && v[SRC_W'(idx)]) begin
                r = {1'b1, SRC_W'(idx)};
            end
        end
        return r;
    endfunction

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
        return SRC_W'((32'(i) + 32'd1) % NUM_REQ);
    endfunction

    assign load_en    = !out_valid || out_ready;
    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign others     = req_valid & ~owner_oh;
    assign idle_pick  = scan(req_valid, 32'(ptr_q));
    assign rot_pick   = scan(others, 32'(next_idx(owner_q)));
    assign keep_owner = req_valid[owner_q] && ((cnt_q < CNT_W'(MAX_BURST)) || !(|others));

    // Grant selection and owner/burst/pointer bookkeeping; frozen while stalled.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_hit = 1'b0;
        grant_idx = '0;
        if (load_en) begin
            if (state_q == S_IDLE) begin
                if (idle_pick[SRC_W]) begin
                    grant_hit = 1'b1;
                    grant_idx = idle_pick[SRC_W-1:0];
                    state_d   = S_BURST;
                    owner_d   = idle_pick[SRC_W-1:0];
                    cnt_d     = CNT_W'(1);
                end
            end else if (keep_owner) begin
                grant_hit = 1'b1;
                grant_idx = owner_q;
                cnt_d     = (cnt_q >= CNT_W'(MAX_BURST)) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end else if (rot_pick[SRC_W]) begin
                grant_hit = 1'b1;
                grant_idx = rot_pick[SRC_W-1:0];
                owner_d   = rot_pick[SRC_W-1:0];
                cnt_d     = CNT_W'(1);
                ptr_d     = next_idx(rot_pick[SRC_W-1:0]);
            end else begin
                state_d = S_IDLE;
                ptr_d   = next_idx(owner_q);
            end
        end
    end

    assign grant_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];
    assign req_ready  = (rst_n && grant_hit) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: a granted beat overwrites the held one in the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (grant_hit) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vif_rr_arbiter.sv
// Directed, table-driven bench for vif_rr_arbiter (MAX_BURST=4 and MAX_BURST=1 instances).
module tb_vif_rr_arbiter;
    localparam logic [31:0] D_DEF = 32'h4332_2110;
    localparam logic [31:0] D_AA  = 32'h4332_AA10;
    localparam logic [31:0] D_BB  = 32'h4332_BB10;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  ready4, ready1;
    logic        ov4, ov1;
    logic [7:0]  od4, od1;
    logic [1:0]  os4, os1;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vif_rr_arbiter #(.DATA_W(8), .NUM_REQ(4), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready4), .out_valid(ov4), .out_data(od4), .out_src(os4),
        .out_ready(out_ready)
    );

    vif_rr_arbiter #(.DATA_W(8), .NUM_REQ(4), .MAX_BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .out_valid(ov1), .out_data(od1), .out_src(os1),
        .out_ready(out_ready)
    );

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o,
                       input logic [3:0] er, input logic ev, input logic [7:0] ed,
                       input logic [1:0] es);
        vec_t t;
        t.rst_n = r; t.valid = v; t.data = d; t.out_ready = o;
        t.exp_ready = er; t.exp_ov = ev; t.exp_od = ed; t.exp_os = es;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o);
        @(negedge clk);
        rst_n = r; req_valid = v; req_data = d; out_ready = o;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dd;
        int          s;

        // Reset with all requesters valid
        repeat (3) add(0, 4'hF, D_DEF, 1, 4'h0, 0, 8'h00, 2'd0);
        // Burst limit: req0 and req2 alternate every 4 beats
        repeat (4) add(1, 4'h5, D_DEF, 1, 4'h1, 1, 8'h10, 2'd0);
        repeat (4) add(1, 4'h5, D_DEF, 1, 4'h4, 1, 8'h32, 2'd2);
        add(1, 4'h5, D_DEF, 1, 4'h1, 1, 8'h10, 2'd0);
        // Backpressure around beat AA from req1
        add(1, 4'h2, D_AA, 1, 4'h2, 1, 8'hAA, 2'd1);
        repeat (5) add(1, 4'h3, D_BB, 0, 4'h0, 1, 8'hAA, 2'd1);
        add(1, 4'h3, D_BB, 1, 4'h2, 1, 8'hBB, 2'd1);
        // Idle pointer: after req2 goes idle, scan starts at req3
        add(1, 4'h4, D_DEF, 1, 4'h4, 1, 8'h32, 2'd2);
        repeat (3) add(1, 4'h0, D_DEF, 1, 4'h0, 0, 8'h32, 2'd2);
        add(1, 4'hA, D_DEF, 1, 4'h8, 1, 8'h43, 2'd3);
        // Empty output loads even with out_ready low, then stalls
        add(1, 4'h0, D_DEF, 1, 4'h0, 0, 8'h43, 2'd3);
        add(1, 4'h1, D_DEF, 0, 4'h1, 1, 8'h10, 2'd0);
        add(1, 4'h1, D_DEF, 0, 4'h0, 1, 8'h10, 2'd0);
        add(1, 4'h1, D_DEF, 1, 4'h1, 1, 8'h10, 2'd0);
        // Mid-burst reset clears the held beat and the scan pointer
        add(1, 4'h2, D_DEF, 1, 4'h2, 1, 8'h21, 2'd1);
        add(1, 4'h2, D_DEF, 1, 4'h2, 1, 8'h21, 2'd1);
        add(0, 4'h3, D_DEF, 1, 4'h0, 0, 8'h00, 2'd0);
        add(1, 4'hF, D_DEF, 1, 4'h1, 1, 8'h10, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].data, vecs[i].out_ready);
            check($sformatf("v%0d req_ready", i), 32'(ready4), 32'(vecs[i].exp_ready));
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", i), 32'(ov4), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d out_data", i), 32'(od4), 32'(vecs[i].exp_od));
            check($sformatf("v%0d out_src", i), 32'(os4), 32'(vecs[i].exp_os));
        end

        // Round robin on the MAX_BURST=1 instance, burst of 4 on the other
        drive(0, 4'hF, D_DEF, 1);
        @(posedge clk); #1;
        dd = D_DEF;
        for (int k = 0; k < 5; k++) begin
            s = k % 4;
            drive(1, 4'hF, D_DEF, 1);
            check($sformatf("rr%0d b1 req_ready", k), 32'(ready1), 32'(4'b1 << s));
            check($sformatf("rr%0d b4 req_ready", k), 32'(ready4), (k < 4) ? 32'h1 : 32'h2);
            @(posedge clk); #1;
            check($sformatf("rr%0d b1 out_src", k), 32'(os1), 32'(s));
            check($sformatf("rr%0d b1 out_data", k), 32'(od1), 32'(dd[s*8 +: 8]));
            check($sformatf("rr%0d b4 out_src", k), 32'(os4), (k < 4) ? 32'd0 : 32'd1);
        end

        // Sole requester keeps the grant past MAX_BURST
        drive(0, 4'h1, D_DEF, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            drive(1, 4'h1, D_DEF, 1);
            check($sformatf("solo%0d req_ready", k), 32'(ready4), 32'h1);
            @(posedge clk); #1;
            check($sformatf("solo%0d out_valid", k), 32'(ov4), 32'h1);
            check($sformatf("solo%0d out_src", k), 32'(os4), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
